// File: rtl/rx_asm_pkg.sv
// Shared types and helpers for the receive word assembler.
package rx_asm_pkg;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   function automatic int cnt_w(input int data_w);
      int c;
      c = $clog2(data_w);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/rx_asm_shifter.sv
// Direction-selectable serial shift register with bit counter; updates 1 cycle after an accepted bit.
// Emits a same-cycle completion strobe and the word that completes; no backpressure, never stalls.
module rx_asm_shifter
   import rx_asm_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SHIFT_MSB = 0,
   localparam int CW       = cnt_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              shift_en_i,
   input  logic              stuff_i,
   input  logic              bit_i,
   output logic [DATA_W-1:0] partial_o,
   output logic [CW-1:0]     bit_cnt_o,
   output logic              done_o,
   output logic [DATA_W-1:0] word_o
);

   logic [DATA_W-1:0] sr_q, sr_d, sr_shift;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              accept;
   logic              last_bit;

   assign accept   = shift_en_i && !stuff_i && !clear_i;
   assign last_bit = (cnt_q == CW'(DATA_W - 1));

   generate
      if (SHIFT_MSB != 0) begin : g_msb_first
         assign sr_shift = {sr_q[DATA_W-2:0], bit_i};
      end else begin : g_lsb_first
         assign sr_shift = {bit_i, sr_q[DATA_W-1:1]};
      end
   endgenerate

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (accept) begin
         sr_d  = sr_shift;
         cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   // Completed word is the register image after this bit shifts in.
   assign done_o    = accept && last_bit;
   assign word_o    = sr_shift;
   assign partial_o = sr_q;
   assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/rx_word_assembler.sv
// Serial-to-parallel receive assembler: word valid 1 cycle after last bit, single-entry valid/ready holding register.
// Completion while full and not accepted is an overrun; RX_ASM_OVERRUN_EN drops the new word and flags it, else it overwrites.
module rx_word_assembler
   import rx_asm_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SHIFT_MSB = 0,
   localparam int CW       = cnt_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift_enable,
   input  logic              serial_in,
   input  logic              stuff_bit,
   output logic [DATA_W-1:0] partial_out,
   output logic [CW-1:0]     bit_cnt,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              overrun
);

   logic              word_done;
   logic [DATA_W-1:0] word_dat;

   hold_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;

   rx_asm_shifter #(
      .DATA_W    (DATA_W),
      .SHIFT_MSB (SHIFT_MSB)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear),
      .shift_en_i (shift_enable),
      .stuff_i    (stuff_bit),
      .bit_i      (serial_in),
      .partial_o  (partial_out),
      .bit_cnt_o  (bit_cnt),
      .done_o     (word_done),
      .word_o     (word_dat)
   );

`ifdef RX_ASM_OVERRUN_EN
   logic ovr_q, ovr_d;
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
`ifdef RX_ASM_OVERRUN_EN
      ovr_d   = ovr_q;
`endif
      case (state_q)
         HOLD_EMPTY: begin
            if (word_done) begin
               state_d = HOLD_FULL;
               data_d  = word_dat;
            end
         end
         HOLD_FULL: begin
            if (word_done) begin
               if (data_ready) begin
                  data_d = word_dat;
               end else begin
`ifdef RX_ASM_OVERRUN_EN
                  ovr_d  = 1'b1;
`else
                  data_d = word_dat;
`endif
               end
            end else if (data_ready) begin
               state_d = HOLD_EMPTY;
            end
         end
         default: state_d = HOLD_EMPTY;
      endcase
`ifdef RX_ASM_OVERRUN_EN
      // clear blocks acceptance, so it can never race a new overrun.
      if (clear) ovr_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

`ifdef RX_ASM_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst) ovr_q <= 1'b0;
      else     ovr_q <= ovr_d;
   end
   assign overrun = ovr_q;
`else
   assign overrun = 1'b0;
`endif

   assign data_out   = data_q;
   assign data_valid = (state_q == HOLD_FULL);

endmodule

// File: tb/tb_rx_word_assembler.sv
// Randomized and directed bench for rx_word_assembler, both shift directions driven in lockstep.
module tb_rx_word_assembler;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, clear, shift_enable, serial_in, stuff_bit, data_ready;
   logic [W-1:0] p0, p1, d0, d1;
   logic [2:0]   c0, c1;
   logic         v0, v1, o0, o1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: accepted bits since last clear/reset, most recent first.
   bit           hist[$];
   int           m_cnt;
   bit           m_v, m_ov;
   logic [W-1:0] m_d0, m_d1;

   always #5 clk = ~clk;

   rx_word_assembler #(.DATA_W(W), .SHIFT_MSB(0)) u_dut0 (
      .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
      .serial_in(serial_in), .stuff_bit(stuff_bit), .partial_out(p0),
      .bit_cnt(c0), .data_out(d0), .data_valid(v0), .data_ready(data_ready),
      .overrun(o0));

   rx_word_assembler #(.DATA_W(W), .SHIFT_MSB(1)) u_dut1 (
      .clk(clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
      .serial_in(serial_in), .stuff_bit(stuff_bit), .partial_out(p1),
      .bit_cnt(c1), .data_out(d1), .data_valid(v1), .data_ready(data_ready),
      .overrun(o1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Newest bit at MSB for LSB-first order, at LSB for MSB-first order.
   function automatic logic [W-1:0] image(input bit msb_first);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < hist.size() && j < W; j++) begin
         if (msb_first) r[j] = hist[j];
         else           r[W-1-j] = hist[j];
      end
      return r;
   endfunction

   task automatic model(input logic se, sb, si, cl, rdy, r);
      bit acc, hs, comp;
      if (r) begin
         hist.delete();
         m_cnt = 0; m_v = 0; m_ov = 0; m_d0 = '0; m_d1 = '0;
         return;
      end
      acc  = se && !sb && !cl;
      hs   = m_v && rdy;
      comp = acc && (m_cnt == W - 1);
      if (cl) begin
         hist.delete();
         m_cnt = 0;
         m_ov  = 0;
      end
      if (acc) begin
         hist.push_front(si);
         if (hist.size() > W) void'(hist.pop_back());
         m_cnt = (m_cnt + 1) % W;
      end
      if (comp) begin
         if (!m_v || hs) begin
            m_d0 = image(0); m_d1 = image(1);
         end else begin
`ifdef RX_ASM_OVERRUN_EN
            m_ov = 1;
`else
            m_d0 = image(0); m_d1 = image(1);
`endif
         end
         m_v = 1;
      end else if (hs) begin
         m_v = 0;
      end
   endtask

   task automatic step(input logic se, sb, si, cl, rdy, r);
      @(negedge clk);
      shift_enable = se; stuff_bit = sb; serial_in = si;
      clear = cl; data_ready = rdy; rst = r;
      @(posedge clk);
      model(se, sb, si, cl, rdy, r);
      #1;
      chk("partial0", p0, image(0));
      chk("partial1", p1, image(1));
      chk("bit_cnt0", c0, m_cnt);
      chk("bit_cnt1", c1, m_cnt);
      chk("data0", d0, m_d0);
      chk("data1", d1, m_d1);
      chk("valid0", v0, m_v);
      chk("valid1", v1, m_v);
      chk("ovr0", o0, m_ov);
      chk("ovr1", o1, m_ov);
   endtask

   // First bit on the wire is v[W-1].
   task automatic send_word(input logic [W-1:0] v, input logic rdy_early, input logic rdy_last);
      for (int i = W - 1; i >= 0; i--)
         step(1'b1, 1'b0, v[i], 1'b0, (i == 0) ? rdy_last : rdy_early, 1'b0);
   endtask

   initial begin
      logic [W-1:0] w;
      rst = 1'b1; clear = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
      stuff_bit = 1'b0; data_ready = 1'b0;
      hist.delete(); m_cnt = 0; m_v = 0; m_ov = 0; m_d0 = '0; m_d1 = '0;

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_valid", v0, 1'b0);
      chk("rst_data", d0, 8'h00);

      // Basic word, both orders, valid for one cycle with ready high.
      step(0, 0, 0, 0, 1, 0);
      send_word(8'b10110010, 1'b1, 1'b1);
      chk("lsb_word", d0, 8'h4D);
      chk("msb_word", d1, 8'hB2);
      chk("word_valid", v0, 1'b1);
      step(0, 0, 0, 0, 1, 0);
      chk("valid_drop", v0, 1'b0);

      // Stuffed 0 after the 4th bit is dropped.
      w = 8'b10110010;
      for (int i = 7; i >= 4; i--) step(1, 0, w[i], 0, 1, 0);
      step(1, 1, 0, 0, 1, 0);
      chk("stuff_cnt", c0, 3'd4);
      for (int i = 3; i >= 0; i--) step(1, 0, w[i], 0, 1, 0);
      chk("stuff_word", d0, 8'h4D);
      step(0, 0, 0, 0, 1, 0);

      // Two words with no consumer.
      send_word(8'h4D, 1'b0, 1'b0);
      send_word(8'hFF, 1'b0, 1'b0);
`ifdef RX_ASM_OVERRUN_EN
      chk("ovr_keep", d0, 8'h4D);
      chk("ovr_flag", o0, 1'b1);
`else
      chk("ovr_over", d0, 8'hFF);
      chk("ovr_flag", o0, 1'b0);
`endif
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("ovr_clear", o0, 1'b0);
      chk("clear_keeps_valid", v0, 1'b1);

      // Completion coincides with handshake of the previous word.
      step(0, 0, 0, 0, 1, 0);
      send_word(8'h4D, 1'b0, 1'b0);
      send_word(8'hFF, 1'b0, 1'b1);
      chk("hs_valid", v0, 1'b1);
      chk("hs_data", d0, 8'hFF);
      chk("hs_ovr", o0, 1'b0);

      // clear together with shift_enable after 5 bits.
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 1, 0, 0);
      chk("clr_cnt", c0, 3'd0);
      chk("clr_partial", p0, 8'h00);
      chk("clr_held", v0, 1'b1);

      // Reset mid-word.
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_mid_partial", p0, 8'h00);
      chk("rst_mid_valid", v0, 1'b0);
      chk("rst_mid_data", d0, 8'h00);

      for (int n = 0; n < 4000; n++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 1'($urandom),
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
